// File: rtl/dma_src_rd.sv
// Source-side DMA read engine: turns one (byte address, byte length) descriptor
// into word-aligned memory reads and hands each word to the byte buffer with lane enables.
module dma_src_rd #(
    parameter int DATA_WD = 32,
    parameter int BE_WD   = DATA_WD / 8,
    parameter int ADDR_WD = 32,
    parameter int LEN_WD  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [ADDR_WD-1:0] cmd_addr_i,
    input  logic [LEN_WD-1:0]  cmd_len_i,
    output logic               mem_req_o,
    output logic [ADDR_WD-1:0] mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [DATA_WD-1:0] mem_rdata_i,
    output logic [DATA_WD-1:0] wdata_o,
    output logic [BE_WD-1:0]   wbe_o,
    output logic               wvalid_o,
    input  logic               wready_i,
    output logic               busy_o,
    output logic               done_o
);
    localparam int OW = $clog2(BE_WD);
    localparam int NW = OW + 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH, S_DONE} state_t;

    state_t             r_state;
    logic [ADDR_WD-1:0] r_addr;
    logic [LEN_WD-1:0]  r_rem;
    logic [OW-1:0]      r_off;
    logic [NW-1:0]      r_n;
    logic [DATA_WD-1:0] r_wdata;
    logic [BE_WD-1:0]   r_wbe;
    logic               r_cmd_ready;
    logic               r_mem_req;
    logic               r_wvalid;
    logic               r_busy;
    logic               r_done;
    logic [NW-1:0]      w_n;

    // Bytes carried by the current word: lanes left above the offset, capped by what remains.
    function automatic logic [NW-1:0] lane_count(input logic [OW-1:0]     off,
                                                 input logic [LEN_WD-1:0] rem);
        logic [LEN_WD-1:0] avail;
        avail = LEN_WD'(BE_WD) - LEN_WD'(off);
        if (rem < avail)
            lane_count = NW'(rem);
        else
            lane_count = NW'(avail);
    endfunction

    function automatic logic [BE_WD-1:0] lane_mask(input logic [OW-1:0] off,
                                                   input logic [NW-1:0] n);
        lane_mask = '0;
        for (int i = 0; i < BE_WD; i++)
            if (i >= int'(off) && i < int'(off) + int'(n))
                lane_mask[i] = 1'b1;
    endfunction

    assign w_n = lane_count(r_off, r_rem);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_off       <= '0;
            r_n         <= '0;
            r_wdata     <= '0;
            r_wbe       <= '0;
            r_cmd_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_addr      <= {cmd_addr_i[ADDR_WD-1:OW], {OW{1'b0}}};
                        r_off       <= cmd_addr_i[OW-1:0];
                        r_rem       <= cmd_len_i;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_len_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_wdata  <= mem_rdata_i;
                        r_n      <= w_n;
                        r_wbe    <= lane_mask(r_off, w_n);
                        r_wvalid <= 1'b1;
                        r_state  <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    // Only the first word can start mid-word; later words begin at lane 0.
                    if (wready_i) begin
                        r_wvalid <= 1'b0;
                        r_off    <= '0;
                        r_rem    <= r_rem - LEN_WD'(r_n);
                        if (r_rem == LEN_WD'(r_n)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr    <= r_addr + ADDR_WD'(BE_WD);
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_mem_req   <= 1'b0;
                    r_wvalid    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = r_addr;
    assign wdata_o     = r_wdata;
    assign wbe_o       = r_wbe;
    assign wvalid_o    = r_wvalid;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule
